// File: rtl/jtag_ir_decoder_if.sv
// ---------------------------------------------------------------------------
// jtag_ir_decoder_if
//   Bundles the TAP-side strobes and the decoded data-register selects of the
//   JTAG instruction register so they can be passed as a single port.
//
//   Signals
//     tlr            TAP is in Test-Logic-Reset
//     capture_ir     Capture-IR strobe
//     shift_ir       Shift-IR strobe
//     update_ir      Update-IR strobe
//     tdi            serial data in
//     unlock         privileged opcodes permitted while high
//     ir_tdo         serial IR data out (LSB of the shift register)
//     ir_value       active (updated) opcode
//     bypass_select  BYPASS register selected
//     id_select      IDCODE register selected
//     bsr_select     boundary-scan register selected
//     bsr_mode       1 = EXTEST (drive pins), 0 = SAMPLE/PRELOAD
//     ahb_select     AHB access register selected
//     user_select    one-hot user data-register selects
//     violation      sticky flag: a privileged opcode was refused
//
//   Modports
//     master  TAP controller / data-register mux side
//     slave   instruction register / decoder side
// ---------------------------------------------------------------------------
interface jtag_ir_decoder_if #(
    parameter int unsigned IR_WIDTH = 5,
    parameter int unsigned NUM_USER = 4
);
    logic                tlr;
    logic                capture_ir;
    logic                shift_ir;
    logic                update_ir;
    logic                tdi;
    logic                unlock;
    logic                ir_tdo;
    logic [IR_WIDTH-1:0] ir_value;
    logic                bypass_select;
    logic                id_select;
    logic                bsr_select;
    logic                bsr_mode;
    logic                ahb_select;
    logic [NUM_USER-1:0] user_select;
    logic                violation;

    modport master (
        output tlr,
        output capture_ir,
        output shift_ir,
        output update_ir,
        output tdi,
        output unlock,
        input  ir_tdo,
        input  ir_value,
        input  bypass_select,
        input  id_select,
        input  bsr_select,
        input  bsr_mode,
        input  ahb_select,
        input  user_select,
        input  violation
    );

    modport slave (
        input  tlr,
        input  capture_ir,
        input  shift_ir,
        input  update_ir,
        input  tdi,
        input  unlock,
        output ir_tdo,
        output ir_value,
        output bypass_select,
        output id_select,
        output bsr_select,
        output bsr_mode,
        output ahb_select,
        output user_select,
        output violation
    );
endinterface

// File: rtl/jtag_ir_decoder.sv
// ---------------------------------------------------------------------------
// jtag_ir_decoder
//   JTAG instruction register with a registered instruction decoder. Captures,
//   shifts and updates an IR_WIDTH-bit instruction and decodes the updated
//   opcode into one-hot data-register selects. User opcodes (and AHB when
//   LOCK_AHB = 1) are privileged: updating one while unlock is low forces the
//   BYPASS select and sets the sticky violation flag.
//
//   Ports
//     TCK    in   only clock, all state moves on the rising edge
//     TRST   in   synchronous, active-high reset
//     jtag   slave modport of jtag_ir_decoder_if (strobes in, selects out)
//
//   Parameters
//     IR_WIDTH    instruction length (>= 4)
//     NUM_USER    number of user data-register selects (>= 1)
//     HAS_IDCODE  reset instruction is IDCODE (1) or BYPASS (0)
//     LOCK_AHB    OP_AHB requires unlock like the user opcodes
//     OP_*        opcode assignments; BYPASS is always all-ones
// ---------------------------------------------------------------------------
module jtag_ir_decoder #(
    parameter int unsigned IR_WIDTH     = 5,
    parameter int unsigned NUM_USER     = 4,
    parameter bit          HAS_IDCODE   = 1'b1,
    parameter bit          LOCK_AHB     = 1'b1,
    parameter int unsigned OP_EXTEST    = 32'h00,
    parameter int unsigned OP_IDCODE    = 32'h01,
    parameter int unsigned OP_SAMPLE    = 32'h02,
    parameter int unsigned OP_PRELOAD   = 32'h03,
    parameter int unsigned OP_AHB       = 32'h04,
    parameter int unsigned OP_USER_BASE = 32'h10
) (
    input  logic             TCK,
    input  logic             TRST,
    jtag_ir_decoder_if.slave jtag
);

    // -----------------------------------------------------------------------
    // Opcode constants truncated to the instruction width
    // -----------------------------------------------------------------------
    localparam logic [IR_WIDTH-1:0] OP_BYPASS_W  = {IR_WIDTH{1'b1}};
    localparam logic [IR_WIDTH-1:0] OP_EXTEST_W  = OP_EXTEST[IR_WIDTH-1:0];
    localparam logic [IR_WIDTH-1:0] OP_IDCODE_W  = OP_IDCODE[IR_WIDTH-1:0];
    localparam logic [IR_WIDTH-1:0] OP_SAMPLE_W  = OP_SAMPLE[IR_WIDTH-1:0];
    localparam logic [IR_WIDTH-1:0] OP_PRELOAD_W = OP_PRELOAD[IR_WIDTH-1:0];
    localparam logic [IR_WIDTH-1:0] OP_AHB_W     = OP_AHB[IR_WIDTH-1:0];
    localparam logic [IR_WIDTH-1:0] RESET_OP     = HAS_IDCODE ? OP_IDCODE_W : OP_BYPASS_W;

    // One register per decoded select; exactly one of bypass/id/bsr/ahb/user
    // is set in any value produced by decode_op.
    typedef struct packed {
        logic                bypass;
        logic                id;
        logic                bsr;
        logic                bsr_mode;
        logic                ahb;
        logic [NUM_USER-1:0] user;
    } sel_t;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------

    // One-hot match of op against OP_USER_BASE + i; all-zero when no user
    // opcode matches.
    function automatic logic [NUM_USER-1:0] user_match(input logic [IR_WIDTH-1:0] op);
        logic [NUM_USER-1:0] hit;
        logic [IR_WIDTH-1:0] uop;
        hit = '0;
        for (int i = 0; i < int'(NUM_USER); i++) begin
            uop = IR_WIDTH'(OP_USER_BASE + 32'(i));
            if (op == uop) begin
                hit[i] = 1'b1;
            end else begin
                hit[i] = 1'b0;
            end
        end
        return hit;
    endfunction

    // First-match decode in the fixed order bypass, idcode, sample/preload,
    // extest, ahb, user; anything unrecognised falls back to bypass.
    function automatic sel_t decode_op(input logic [IR_WIDTH-1:0] op);
        sel_t s;
        s = '0;
        if (op == OP_BYPASS_W) begin
            s.bypass = 1'b1;
        end else if (op == OP_IDCODE_W) begin
            s.id = 1'b1;
        end else if ((op == OP_SAMPLE_W) || (op == OP_PRELOAD_W)) begin
            s.bsr      = 1'b1;
            s.bsr_mode = 1'b0;
        end else if (op == OP_EXTEST_W) begin
            s.bsr      = 1'b1;
            s.bsr_mode = 1'b1;
        end else if (op == OP_AHB_W) begin
            s.ahb = 1'b1;
        end else begin
            s.user = user_match(op);
            if (s.user == '0) begin
                s.bypass = 1'b1;
            end else begin
                s.bypass = 1'b0;
            end
        end
        return s;
    endfunction

    // A decoded select is privileged when it is a user select, or the AHB
    // select while AHB is locked. Evaluated after first-match decode so an
    // overlapping lower-priority privileged opcode never taints a public one.
    function automatic logic is_privileged(input sel_t s);
        return (|s.user) | (LOCK_AHB & s.ahb);
    endfunction

    // Select vector for the forced-bypass result of a refused update.
    function automatic sel_t bypass_sel();
        sel_t s;
        s        = '0;
        s.bypass = 1'b1;
        return s;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [IR_WIDTH-1:0] shift_r;
    logic [IR_WIDTH-1:0] active_r;
    sel_t                sel_r;
    logic                violation_r;

    logic [IR_WIDTH-1:0] shift_nxt_s;
    logic [IR_WIDTH-1:0] active_nxt_s;
    sel_t                sel_nxt_s;
    logic                violation_nxt_s;

    logic [IR_WIDTH-1:0] capture_s;
    sel_t                dec_s;
    sel_t                rst_sel_s;

    // Decode of the reset opcode; constant after elaboration.
    assign rst_sel_s = decode_op(RESET_OP);

    // Decode of the shift register, used on the update edge.
    assign dec_s = decode_op(shift_r);

    // Capture pattern: status bits above the mandatory 2'b01 LSBs.
    always_comb begin
        capture_s    = '0;
        capture_s[3] = violation_r;
        capture_s[2] = ~jtag.unlock;
        capture_s[1] = 1'b0;
        capture_s[0] = 1'b1;
    end

    // Next-state logic; strobe priority tlr > update > capture > shift
    // (TRST is handled in the register process above all of these).
    always_comb begin
        shift_nxt_s     = shift_r;
        active_nxt_s    = active_r;
        sel_nxt_s       = sel_r;
        violation_nxt_s = violation_r;
        if (jtag.tlr) begin
            shift_nxt_s     = RESET_OP;
            active_nxt_s    = RESET_OP;
            sel_nxt_s       = rst_sel_s;
            violation_nxt_s = 1'b0;
        end else if (jtag.update_ir) begin
            // ir_value always reflects the shifted opcode, even when refused.
            active_nxt_s = shift_r;
            if (is_privileged(dec_s) && !jtag.unlock) begin
                sel_nxt_s       = bypass_sel();
                violation_nxt_s = 1'b1;
            end else begin
                sel_nxt_s       = dec_s;
                violation_nxt_s = violation_r;
            end
        end else if (jtag.capture_ir) begin
            shift_nxt_s = capture_s;
        end else if (jtag.shift_ir) begin
            // LSB leaves on ir_tdo, tdi enters at the MSB.
            shift_nxt_s = {jtag.tdi, shift_r[IR_WIDTH-1:1]};
        end else begin
            shift_nxt_s = shift_r;
        end
    end

    // State registers with synchronous TRST.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            shift_r     <= RESET_OP;
            active_r    <= RESET_OP;
            sel_r       <= rst_sel_s;
            violation_r <= 1'b0;
        end else begin
            shift_r     <= shift_nxt_s;
            active_r    <= active_nxt_s;
            sel_r       <= sel_nxt_s;
            violation_r <= violation_nxt_s;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (all driven straight from registers)
    // -----------------------------------------------------------------------
    assign jtag.ir_tdo        = shift_r[0];
    assign jtag.ir_value      = active_r;
    assign jtag.bypass_select = sel_r.bypass;
    assign jtag.id_select     = sel_r.id;
    assign jtag.bsr_select    = sel_r.bsr;
    assign jtag.bsr_mode      = sel_r.bsr_mode;
    assign jtag.ahb_select    = sel_r.ahb;
    assign jtag.user_select   = sel_r.user;
    assign jtag.violation     = violation_r;

endmodule

// File: tb/tb_jtag_ir_decoder.sv
// ---------------------------------------------------------------------------
// tb_jtag_ir_decoder
//   Directed bench for jtag_ir_decoder. Main instance uses the default
//   parameters; a second instance with HAS_IDCODE = 0 covers the BYPASS
//   reset opcode. Select vectors are compared as
//   {bypass, id, bsr, bsr_mode, ahb, user[3:0]}.
// ---------------------------------------------------------------------------
module tb_jtag_ir_decoder;

    logic TCK;
    logic TRST;
    int   checks;
    int   errors;

    jtag_ir_decoder_if #(.IR_WIDTH(5), .NUM_USER(4)) jif ();
    jtag_ir_decoder_if #(.IR_WIDTH(5), .NUM_USER(4)) jif_b ();

    jtag_ir_decoder #(.IR_WIDTH(5), .NUM_USER(4), .HAS_IDCODE(1'b1), .LOCK_AHB(1'b1)) dut (
        .TCK  (TCK),
        .TRST (TRST),
        .jtag (jif.slave)
    );

    jtag_ir_decoder #(.IR_WIDTH(5), .NUM_USER(4), .HAS_IDCODE(1'b0), .LOCK_AHB(1'b1)) dut_b (
        .TCK  (TCK),
        .TRST (TRST),
        .jtag (jif_b.slave)
    );

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    function automatic logic [8:0] sel_a();
        return {jif.bypass_select, jif.id_select, jif.bsr_select, jif.bsr_mode,
                jif.ahb_select, jif.user_select};
    endfunction

    function automatic logic [8:0] sel_b();
        return {jif_b.bypass_select, jif_b.id_select, jif_b.bsr_select, jif_b.bsr_mode,
                jif_b.ahb_select, jif_b.user_select};
    endfunction

    task automatic tick();
        @(posedge TCK);
        #1;
    endtask

    task automatic do_capture();
        jif.capture_ir = 1'b1;
        tick();
        jif.capture_ir = 1'b0;
    endtask

    task automatic do_shift(input logic b);
        jif.tdi      = b;
        jif.shift_ir = 1'b1;
        tick();
        jif.shift_ir = 1'b0;
    endtask

    task automatic do_update();
        jif.update_ir = 1'b1;
        tick();
        jif.update_ir = 1'b0;
    endtask

    task automatic load_op(input logic [4:0] op);
        do_capture();
        for (int i = 0; i < 5; i++) do_shift(op[i]);
        do_update();
    endtask

    task automatic test_reset();
        TRST = 1'b1;
        tick();
        TRST = 1'b0;
        checks++; if (jif.ir_value !== 5'h01) begin errors++; $display("FAIL reset_ir_value got %h exp %h", jif.ir_value, 5'h01); end
        checks++; if (sel_a() !== 9'b0_1_0_0_0_0000) begin errors++; $display("FAIL reset_selects got %b exp %b", sel_a(), 9'b0_1_0_0_0_0000); end
        checks++; if (jif.violation !== 1'b0) begin errors++; $display("FAIL reset_violation got %b exp 0", jif.violation); end
        checks++; if (jif.ir_tdo !== 1'b1) begin errors++; $display("FAIL reset_tdo got %b exp 1", jif.ir_tdo); end
        checks++; if (jif_b.ir_value !== 5'h1F) begin errors++; $display("FAIL reset_b_ir_value got %h exp %h", jif_b.ir_value, 5'h1F); end
        checks++; if (sel_b() !== 9'b1_0_0_0_0_0000) begin errors++; $display("FAIL reset_b_selects got %b exp %b", sel_b(), 9'b1_0_0_0_0_0000); end
        checks++; if (jif_b.ir_tdo !== 1'b1) begin errors++; $display("FAIL reset_b_tdo got %b exp 1", jif_b.ir_tdo); end
    endtask

    task automatic test_capture_shift();
        logic [4:0] tdi_v;
        logic [4:0] tdo_v;
        tdi_v = 5'b00101;   // applied LSB first: 1,0,1,0,0
        tdo_v = 5'b00001;   // captured pattern seen LSB first: 1,0,0,0,0
        jif.unlock = 1'b1;
        do_capture();
        for (int i = 0; i < 5; i++) begin
            checks++; if (jif.ir_tdo !== tdo_v[i]) begin errors++; $display("FAIL cap_tdo[%0d] got %b exp %b", i, jif.ir_tdo, tdo_v[i]); end
            do_shift(tdi_v[i]);
            checks++; if (sel_a() !== 9'b0_1_0_0_0_0000) begin errors++; $display("FAIL shift_hold[%0d] got %b exp %b", i, sel_a(), 9'b0_1_0_0_0_0000); end
        end
        do_update();
        checks++; if (jif.ir_value !== 5'h05) begin errors++; $display("FAIL cap_ir_value got %h exp %h", jif.ir_value, 5'h05); end
        checks++; if (sel_a() !== 9'b1_0_0_0_0_0000) begin errors++; $display("FAIL cap_unknown_bypass got %b exp %b", sel_a(), 9'b1_0_0_0_0_0000); end
    endtask

    task automatic test_decode_sweep();
        logic [4:0] ops [9];
        logic [8:0] exp [9];
        ops = '{5'h1F, 5'h00, 5'h02, 5'h03, 5'h04, 5'h10, 5'h11, 5'h12, 5'h13};
        exp = '{9'b1_0_0_0_0_0000, 9'b0_0_1_1_0_0000, 9'b0_0_1_0_0_0000,
                9'b0_0_1_0_0_0000, 9'b0_0_0_0_1_0000, 9'b0_0_0_0_0_0001,
                9'b0_0_0_0_0_0010, 9'b0_0_0_0_0_0100, 9'b0_0_0_0_0_1000};
        jif.unlock = 1'b1;
        for (int k = 0; k < 9; k++) begin
            load_op(ops[k]);
            checks++; if (jif.ir_value !== ops[k]) begin errors++; $display("FAIL sweep_ir_value op=%h got %h", ops[k], jif.ir_value); end
            checks++; if (sel_a() !== exp[k]) begin errors++; $display("FAIL sweep_selects op=%h got %b exp %b", ops[k], sel_a(), exp[k]); end
        end
        checks++; if (jif.violation !== 1'b0) begin errors++; $display("FAIL sweep_violation got %b exp 0", jif.violation); end
    endtask

    task automatic test_lock();
        logic [4:0] cap_v;
        cap_v = 5'b01101;
        jif.unlock = 1'b0;
        load_op(5'h12);
        checks++; if (jif.ir_value !== 5'h12) begin errors++; $display("FAIL lock_ir_value got %h exp %h", jif.ir_value, 5'h12); end
        checks++; if (sel_a() !== 9'b1_0_0_0_0_0000) begin errors++; $display("FAIL lock_user_selects got %b exp %b", sel_a(), 9'b1_0_0_0_0_0000); end
        checks++; if (jif.violation !== 1'b1) begin errors++; $display("FAIL lock_violation got %b exp 1", jif.violation); end
        do_capture();
        for (int i = 0; i < 5; i++) begin
            checks++; if (jif.ir_tdo !== cap_v[i]) begin errors++; $display("FAIL lock_capture[%0d] got %b exp %b", i, jif.ir_tdo, cap_v[i]); end
            do_shift(1'b0);
        end
        load_op(5'h04);
        checks++; if (jif.ir_value !== 5'h04) begin errors++; $display("FAIL lock_ahb_ir_value got %h exp %h", jif.ir_value, 5'h04); end
        checks++; if (sel_a() !== 9'b1_0_0_0_0_0000) begin errors++; $display("FAIL lock_ahb_selects got %b exp %b", sel_a(), 9'b1_0_0_0_0_0000); end
        checks++; if (jif.violation !== 1'b1) begin errors++; $display("FAIL lock_ahb_violation got %b exp 1", jif.violation); end
    endtask

    task automatic test_unlock_clear();
        jif.unlock = 1'b1;
        load_op(5'h12);
        checks++; if (sel_a() !== 9'b0_0_0_0_0_0100) begin errors++; $display("FAIL unlock_user got %b exp %b", sel_a(), 9'b0_0_0_0_0_0100); end
        checks++; if (jif.violation !== 1'b1) begin errors++; $display("FAIL unlock_sticky got %b exp 1", jif.violation); end
        jif.unlock = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (sel_a() !== 9'b0_0_0_0_0_0100) begin errors++; $display("FAIL unlock_hold got %b exp %b", sel_a(), 9'b0_0_0_0_0_0100); end
        jif.tlr = 1'b1;
        tick();
        jif.tlr = 1'b0;
        checks++; if (jif.ir_value !== 5'h01) begin errors++; $display("FAIL tlr_ir_value got %h exp %h", jif.ir_value, 5'h01); end
        checks++; if (sel_a() !== 9'b0_1_0_0_0_0000) begin errors++; $display("FAIL tlr_selects got %b exp %b", sel_a(), 9'b0_1_0_0_0_0000); end
        checks++; if (jif.violation !== 1'b0) begin errors++; $display("FAIL tlr_violation got %b exp 0", jif.violation); end
    endtask

    task automatic test_mid_reset_priority();
        jif.unlock = 1'b1;
        do_capture();
        for (int i = 0; i < 3; i++) do_shift(1'b1);
        TRST = 1'b1;
        tick();
        TRST = 1'b0;
        checks++; if (jif.ir_tdo !== 1'b1) begin errors++; $display("FAIL midrst_tdo got %b exp 1", jif.ir_tdo); end
        // Capture would load 'b00101 with unlock low; update must win instead.
        jif.unlock     = 1'b0;
        jif.capture_ir = 1'b1;
        jif.update_ir  = 1'b1;
        tick();
        jif.capture_ir = 1'b0;
        jif.update_ir  = 1'b0;
        checks++; if (jif.ir_value !== 5'h01) begin errors++; $display("FAIL midrst_update_ir_value got %h exp %h", jif.ir_value, 5'h01); end
        checks++; if (sel_a() !== 9'b0_1_0_0_0_0000) begin errors++; $display("FAIL midrst_selects got %b exp %b", sel_a(), 9'b0_1_0_0_0_0000); end
        checks++; if (jif.violation !== 1'b0) begin errors++; $display("FAIL midrst_violation got %b exp 0", jif.violation); end
        do_shift(1'b0);
        do_shift(1'b0);
        checks++; if (jif.ir_tdo !== 1'b0) begin errors++; $display("FAIL prio_no_capture got %b exp 0", jif.ir_tdo); end
        // tlr beats a simultaneous update of a user opcode.
        jif.unlock = 1'b1;
        do_capture();
        for (int i = 0; i < 5; i++) do_shift(i == 0 || i == 1 || i == 4);
        jif.tlr       = 1'b1;
        jif.update_ir = 1'b1;
        tick();
        jif.tlr       = 1'b0;
        jif.update_ir = 1'b0;
        checks++; if (jif.ir_value !== 5'h01) begin errors++; $display("FAIL prio_tlr_ir_value got %h exp %h", jif.ir_value, 5'h01); end
        checks++; if (sel_a() !== 9'b0_1_0_0_0_0000) begin errors++; $display("FAIL prio_tlr_selects got %b exp %b", sel_a(), 9'b0_1_0_0_0_0000); end
        // Follow-up update confirms the shift register was reset too.
        do_update();
        checks++; if (jif.ir_value !== 5'h01) begin errors++; $display("FAIL prio_tlr_shift got %h exp %h", jif.ir_value, 5'h01); end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        TRST             = 1'b1;
        jif.tlr          = 1'b0;
        jif.capture_ir   = 1'b0;
        jif.shift_ir     = 1'b0;
        jif.update_ir    = 1'b0;
        jif.tdi          = 1'b0;
        jif.unlock       = 1'b0;
        jif_b.tlr        = 1'b0;
        jif_b.capture_ir = 1'b0;
        jif_b.shift_ir   = 1'b0;
        jif_b.update_ir  = 1'b0;
        jif_b.tdi        = 1'b0;
        jif_b.unlock     = 1'b0;
        tick();
        test_reset();
        test_capture_shift();
        test_decode_sweep();
        test_lock();
        test_unlock_clear();
        test_mid_reset_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_ir_decoder.md
# jtag_ir_decoder

Parametrised JTAG instruction register plus registered instruction decoder. It sits between the TAP controller and the data-register mux. It captures, shifts and updates an IR_WIDTH-bit instruction, then decodes the updated opcode into one-hot data-register selects, including a bank of NUM_USER user registers. Privileged opcodes (user and, optionally, AHB) are gated by an unlock input, and refused attempts are recorded in a sticky violation flag.

## Interface
Parameters:
- IR_WIDTH, 5: instruction length in bits; must be ≥ 4.
- NUM_USER, 4: number of user data-register selects; must be ≥ 1; OP_USER_BASE + NUM_USER − 1 must be < 2^IR_WIDTH.
- HAS_IDCODE, 1: selects the reset instruction; 1 means IDCODE, 0 means BYPASS.
- LOCK_AHB, 1: when 1, OP_AHB is privileged (same unlock rule as user opcodes).
- OP_EXTEST 'h00, OP_IDCODE 'h01, OP_SAMPLE 'h02, OP_PRELOAD 'h03, OP_AHB 'h04, OP_USER_BASE 'h10: opcodes. BYPASS is fixed at all-ones.

Ports:
- TCK, in, 1: the only clock; all state updates on the rising edge.
- TRST, in, 1: reset, synchronous, active-high.
- tlr, in, 1: TAP is in Test-Logic-Reset.
- capture_ir / shift_ir / update_ir, in, 1 each: TAP state strobes.
- tdi, in, 1: serial data in.
- unlock, in, 1: privileged opcodes are permitted while high.
- ir_tdo, out, 1: serial IR data out; equals shift_reg[0] (combinational; the TAP output stage retimes it to the falling edge).
- ir_value, out, IR_WIDTH: the active (updated) opcode.
- bypass_select, id_select, bsr_select, bsr_mode, ahb_select, out, 1 each: decoded selects.
- user_select, out, NUM_USER: one-hot user selects; bit i corresponds to opcode OP_USER_BASE + i.
- violation, out, 1: sticky flag, set when a privileged opcode is refused.

## Operation
- State: shift_reg[IR_WIDTH], active_ir[IR_WIDTH], registered selects, violation.
- Priority per edge: TRST > tlr > update_ir > capture_ir > shift_ir.
- TRST or tlr:
  - active_ir = reset opcode (OP_IDCODE if HAS_IDCODE, else all-ones).
  - shift_reg = same value.
  - Selects = decode of the reset opcode.
  - violation = 0.
- capture_ir: shift_reg = {zeros, violation, ~unlock, 1'b0, 1'b1}. The LSBs 01 are mandatory.
- shift_ir: shift_reg = {tdi, shift_reg[IR_WIDTH-1:1]}, LSB first out.
- update_ir: active_ir = shift_reg. All selects are registered from the decode of shift_reg on the same edge.
- Decode. Exactly one of bypass / id / bsr / ahb / user is active at any time:
  - All-ones → bypass_select.
  - OP_IDCODE → id_select.
  - OP_SAMPLE, OP_PRELOAD → bsr_select, bsr_mode = 0.
  - OP_EXTEST → bsr_select, bsr_mode = 1.
  - OP_AHB → ahb_select.
  - OP_USER_BASE + i → user_select[i].
  - Any other opcode → bypass_select.
- Privilege:
  - Applies to user opcodes, and to OP_AHB when LOCK_AHB = 1.
  - At update with unlock = 0: the decode is forced to bypass_select and violation is set.
  - ir_value still shows the shifted opcode.
- violation clears only on TRST or tlr.
- Opcode overlap: if parameter opcodes overlap, the first match in the decode order above wins.
- No strobe: all state holds.

## Timing
- Selects and ir_value change on the update_ir edge and are valid in the cycle immediately after it.
- During capture and shift, selects hold their previous values.
- ir_tdo changes in the cycle after each capture or shift edge.
- Reset values:
  - ir_value = reset opcode.
  - id_select = HAS_IDCODE; bypass_select = ~HAS_IDCODE.
  - All other selects, bsr_mode and violation = 0.
  - ir_tdo = LSB of the reset opcode.
- Simultaneous strobes (illegal from a compliant TAP): resolved by the priority list above.
- TRST or tlr arriving mid-shift discards the partial shift. The next update then loads whatever capture/shift produces afterwards.
- unlock is sampled only on the update edge. Dropping unlock after a privileged opcode has been updated does not revoke the select.

## Test plan
- Reset: assert TRST for 1 cycle → ir_value = 'h01, id_select = 1, every other select = 0, violation = 0. Repeat with HAS_IDCODE = 0 → ir_value = 'h1F, bypass_select = 1.
- Capture and shift: unlock = 1, violation = 0; capture, then 5 shifts with tdi = 1,0,1,0,0 → ir_tdo sequence 1,0,0,0,0 (capture 'b00001, LSB first). Update → ir_value = 'h05, bypass_select = 1 (unknown opcode).
- Full decode sweep: for each of 'h00, 'h02, 'h03, 'h04, 'h10..'h13, 'h1F, shift and update → exactly the expected select one-hot. EXTEST gives bsr_mode = 1; SAMPLE and PRELOAD give bsr_mode = 0.
- Lock: unlock = 0, update 'h12 → bypass_select = 1, user_select = 0, violation = 1. Next capture loads 'b01101. Repeat with 'h04 and LOCK_AHB = 1 → bypass_select = 1, violation stays 1.
- Unlock and clear: unlock = 1, update 'h12 → user_select = 'b0100. Then drop unlock → select holds. Pulse tlr → ir_value = 'h01, violation = 0.
- Mid-operation reset and priority: TRST after 3 of 5 shifts → shift_reg = 'h01. Then capture_ir and update_ir asserted together → update wins and loads 'h01.
